// File: rtl/byteswap_stream_swapper.sv
// byteswap_stream_swapper
//   Streams AXI4-Stream beats through a C_NUM_STAGES-deep elastic pipeline.
//   Each C_WORD_BIT_WIDTH slice is transformed according to the mode latched
//   at transfer start: 0 pass, 1 byte reverse, 2 halfword swap, 3 bit reverse
//   within each byte. tkeep follows the data byte mapping. tlast passes through.
// Ports
//   aclk, areset                 clock, asynchronous active-high reset
//   ctrl_start, ctrl_mode        start pulse and mode (sampled in IDLE only)
//   ctrl_busy, ctrl_done         transfer in progress, one-cycle completion pulse
//   ctrl_beat_count              saturating count of output beats this transfer
//   s_axis_*                     input stream (tvalid/tready/tdata/tkeep/tlast)
//   m_axis_*                     output stream (tvalid/tready/tdata/tkeep/tlast)
module byteswap_stream_swapper #(
   parameter int unsigned C_AXIS_TDATA_WIDTH = 512,
   parameter int unsigned C_WORD_BIT_WIDTH   = 32,
   parameter int unsigned C_NUM_STAGES       = 2,
   parameter int unsigned C_COUNT_WIDTH      = 32
) (
   input  logic                            aclk,
   input  logic                            areset,
   input  logic                            ctrl_start,
   input  logic [1:0]                      ctrl_mode,
   output logic                            ctrl_busy,
   output logic                            ctrl_done,
   output logic [C_COUNT_WIDTH-1:0]        ctrl_beat_count,
   input  logic                            s_axis_tvalid,
   output logic                            s_axis_tready,
   input  logic                            s_axis_tlast,
   input  logic [C_AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
   input  logic [C_AXIS_TDATA_WIDTH/8-1:0] s_axis_tkeep,
   output logic                            m_axis_tvalid,
   input  logic                            m_axis_tready,
   output logic                            m_axis_tlast,
   output logic [C_AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
   output logic [C_AXIS_TDATA_WIDTH/8-1:0] m_axis_tkeep
);

   localparam int unsigned KEEP_W     = C_AXIS_TDATA_WIDTH / 8;
   localparam int unsigned NUM_WORDS  = C_AXIS_TDATA_WIDTH / C_WORD_BIT_WIDTH;
   localparam int unsigned WORD_BYTES = C_WORD_BIT_WIDTH / 8;
   localparam int unsigned NS         = C_NUM_STAGES;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DRAIN
   } state_t;

   state_t                   state_q, state_d;
   logic [1:0]               mode_q, mode_d;
   logic [C_COUNT_WIDTH-1:0] count_q, count_d;
   logic                     done_q, done_d;

   logic [NS-1:0]            valid_q, valid_d;
   logic [NS-1:0]            ready;
   logic [NS-1:0]            last_q;
   logic [C_AXIS_TDATA_WIDTH-1:0] data_q [NS];
   logic [KEEP_W-1:0]             keep_q [NS];

   logic [C_AXIS_TDATA_WIDTH-1:0] xf_data;
   logic [KEEP_W-1:0]             xf_keep;
   logic                          s_hs, m_hs;

   // Per-word transform: modes 1 and 2 are both byte permutations (a halfword
   // swap is a rotation by half the word's bytes), mode 3 keeps byte order and
   // mirrors bits inside each byte. tkeep uses the same source byte index.
   always_comb begin
      int unsigned src;
      logic [7:0]  byte_v;
      xf_data = s_axis_tdata;
      xf_keep = s_axis_tkeep;
      src     = 0;
      byte_v  = '0;
      for (int unsigned w = 0; w < NUM_WORDS; w++) begin
         for (int unsigned b = 0; b < WORD_BYTES; b++) begin
            case (mode_q)
               2'd1:    src = WORD_BYTES - 1 - b;
               2'd2:    src = (b + WORD_BYTES / 2) % WORD_BYTES;
               default: src = b;
            endcase
            byte_v = s_axis_tdata[w*C_WORD_BIT_WIDTH + src*8 +: 8];
            if (mode_q == 2'd3) begin
               for (int unsigned k = 0; k < 8; k++) begin
                  xf_data[w*C_WORD_BIT_WIDTH + b*8 + k] = byte_v[7-k];
               end
            end else begin
               xf_data[w*C_WORD_BIT_WIDTH + b*8 +: 8] = byte_v;
            end
            xf_keep[w*WORD_BYTES + b] = s_axis_tkeep[w*WORD_BYTES + src];
         end
      end
   end

   // Stage i may load when some stage at or after it is empty, or the output
   // is being accepted; written in closed form to avoid a combinational chain
   // through the ready vector itself.
   always_comb begin
      ready = '0;
      for (int unsigned i = 0; i < NS; i++) begin
         ready[i] = m_axis_tready;
         for (int unsigned j = i; j < NS; j++) begin
            if (!valid_q[j]) ready[i] = 1'b1;
         end
      end
   end

   assign s_axis_tready = (state_q == ST_RUN) && ready[0];
   assign s_hs          = s_axis_tvalid && s_axis_tready;
   assign m_hs          = m_axis_tvalid && m_axis_tready;

   always_comb begin
      valid_d = valid_q;
      if (ready[0]) valid_d[0] = s_hs;
      for (int unsigned i = 1; i < NS; i++) begin
         if (ready[i]) valid_d[i] = valid_q[i-1];
      end
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) valid_q <= '0;
      else        valid_q <= valid_d;
   end

   // Payload registers carry no reset; valid_q qualifies them.
   always_ff @(posedge aclk) begin
      if (ready[0]) begin
         data_q[0] <= xf_data;
         keep_q[0] <= xf_keep;
         last_q[0] <= s_axis_tlast;
      end
      for (int unsigned i = 1; i < NS; i++) begin
         if (ready[i]) begin
            data_q[i] <= data_q[i-1];
            keep_q[i] <= keep_q[i-1];
            last_q[i] <= last_q[i-1];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      count_d = count_q;
      done_d  = 1'b0;
      if (m_hs && (count_q != '1)) count_d = count_q + 1'b1;
      case (state_q)
         ST_IDLE: begin
            if (ctrl_start) begin
               mode_d  = ctrl_mode;
               count_d = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (s_hs && s_axis_tlast) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (m_hs && m_axis_tlast) begin
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state_q <= ST_IDLE;
         mode_q  <= '0;
         count_q <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         count_q <= count_d;
         done_q  <= done_d;
      end
   end

   assign ctrl_busy       = (state_q != ST_IDLE);
   assign ctrl_done       = done_q;
   assign ctrl_beat_count = count_q;
   assign m_axis_tvalid   = valid_q[NS-1];
   assign m_axis_tdata    = data_q[NS-1];
   assign m_axis_tkeep    = keep_q[NS-1];
   assign m_axis_tlast    = last_q[NS-1];

endmodule

// File: tb/tb_byteswap_stream_swapper.sv
// Testbench for byteswap_stream_swapper: 512-bit stream, 32-bit words,
// two pipeline stages. Reference transform and scoreboard live here.
module tb_byteswap_stream_swapper;

   localparam int unsigned D      = 512;
   localparam int unsigned KW     = D / 8;
   localparam int unsigned NS     = 2;
   localparam int          BUDGET = 3000;

   logic          aclk = 1'b0;
   logic          areset;
   logic          ctrl_start;
   logic [1:0]    ctrl_mode;
   logic          ctrl_busy;
   logic          ctrl_done;
   logic [31:0]   ctrl_beat_count;
   logic          s_axis_tvalid, s_axis_tready, s_axis_tlast;
   logic [D-1:0]  s_axis_tdata;
   logic [KW-1:0] s_axis_tkeep;
   logic          m_axis_tvalid, m_axis_tready, m_axis_tlast;
   logic [D-1:0]  m_axis_tdata;
   logic [KW-1:0] m_axis_tkeep;

   int n_checks = 0;
   int n_errors = 0;

   logic [D-1:0]  exp_d [$];
   logic [KW-1:0] exp_k [$];
   logic          exp_l [$];

   always #5 aclk = ~aclk;

   byteswap_stream_swapper #(
      .C_AXIS_TDATA_WIDTH(D),
      .C_WORD_BIT_WIDTH  (32),
      .C_NUM_STAGES      (NS),
      .C_COUNT_WIDTH     (32)
   ) dut (
      .aclk           (aclk),
      .areset         (areset),
      .ctrl_start     (ctrl_start),
      .ctrl_mode      (ctrl_mode),
      .ctrl_busy      (ctrl_busy),
      .ctrl_done      (ctrl_done),
      .ctrl_beat_count(ctrl_beat_count),
      .s_axis_tvalid  (s_axis_tvalid),
      .s_axis_tready  (s_axis_tready),
      .s_axis_tlast   (s_axis_tlast),
      .s_axis_tdata   (s_axis_tdata),
      .s_axis_tkeep   (s_axis_tkeep),
      .m_axis_tvalid  (m_axis_tvalid),
      .m_axis_tready  (m_axis_tready),
      .m_axis_tlast   (m_axis_tlast),
      .m_axis_tdata   (m_axis_tdata),
      .m_axis_tkeep   (m_axis_tkeep)
   );

   task automatic check_eq(input string tag, input logic [D-1:0] got, input logic [D-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] bitrev8(input logic [7:0] x);
      return {x[0], x[1], x[2], x[3], x[4], x[5], x[6], x[7]};
   endfunction

   function automatic logic [D-1:0] ref_data(input logic [1:0] mode, input logic [D-1:0] d);
      logic [D-1:0] r;
      logic [31:0]  w, o;
      r = '0;
      for (int i = 0; i < 16; i++) begin
         w = d[i*32 +: 32];
         case (mode)
            2'd1: o = {w[7:0], w[15:8], w[23:16], w[31:24]};
            2'd2: o = {w[15:0], w[31:16]};
            2'd3: o = {bitrev8(w[31:24]), bitrev8(w[23:16]), bitrev8(w[15:8]), bitrev8(w[7:0])};
            default: o = w;
         endcase
         r[i*32 +: 32] = o;
      end
      return r;
   endfunction

   function automatic logic [KW-1:0] ref_keep(input logic [1:0] mode, input logic [KW-1:0] k);
      logic [KW-1:0] r;
      logic [3:0]    n;
      r = '0;
      for (int i = 0; i < 16; i++) begin
         n = k[i*4 +: 4];
         case (mode)
            2'd1: r[i*4 +: 4] = {n[0], n[1], n[2], n[3]};
            2'd2: r[i*4 +: 4] = {n[1:0], n[3:2]};
            default: r[i*4 +: 4] = n;
         endcase
      end
      return r;
   endfunction

   function automatic logic [D-1:0] rand512();
      logic [D-1:0] r;
      for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom();
      return r;
   endfunction

   // One beat with a known low word; checks latency, transform, done and count.
   task automatic directed_one(input logic [1:0] mode, input logic [31:0] din, input logic [3:0] kin,
                               input logic [31:0] dexp, input logic [3:0] kexp);
      int lat;
      bit seen;
      @(posedge aclk); #1;
      ctrl_start = 1'b1; ctrl_mode = mode; m_axis_tready = 1'b1;
      @(posedge aclk); #1;
      ctrl_start = 1'b0;
      s_axis_tvalid = 1'b1; s_axis_tlast = 1'b1;
      s_axis_tdata = '0; s_axis_tdata[31:0] = din;
      s_axis_tkeep = '0; s_axis_tkeep[3:0] = kin;
      @(negedge aclk);
      check_eq("dir_busy", D'(ctrl_busy), D'(1));
      check_eq("dir_accept", D'(s_axis_tready), D'(1));
      @(posedge aclk); #1;
      s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
      lat = 0; seen = 1'b0;
      for (int i = 1; i <= 8 && !seen; i++) begin
         @(negedge aclk);
         if (m_axis_tvalid) begin seen = 1'b1; lat = i; end
      end
      check_eq("dir_latency", D'(lat), D'(NS));
      check_eq("dir_data", m_axis_tdata, {{(D-32){1'b0}}, dexp});
      check_eq("dir_keep", D'(m_axis_tkeep), D'(kexp));
      check_eq("dir_last", D'(m_axis_tlast), D'(1));
      @(negedge aclk);
      check_eq("dir_done", D'(ctrl_done), D'(1));
      check_eq("dir_count", D'(ctrl_beat_count), D'(1));
      @(negedge aclk);
      check_eq("dir_done_width", D'(ctrl_done), D'(0));
      check_eq("dir_idle", D'(ctrl_busy), D'(0));
   endtask

   task automatic run_stream(input logic [1:0] mode, input int nbeats, input int rdy_pct,
                             input int stall_from, input int stall_len, input bit poke_start);
      int sent, recv, dones, cyc;
      bit shs, mhs, prev_stall, valid_always;
      logic [D-1:0]  held_d;
      logic [KW+1:0] held_c;
      sent = 0; recv = 0; dones = 0; cyc = 0;
      shs = 1'b0; mhs = 1'b0; prev_stall = 1'b0;
      held_d = '0; held_c = '0;
      valid_always = (stall_len > 0);
      exp_d.delete(); exp_k.delete(); exp_l.delete();
      @(posedge aclk); #1;
      ctrl_start = 1'b1; ctrl_mode = mode;
      @(posedge aclk); #1;
      ctrl_start = 1'b0;
      while (cyc < BUDGET) begin
         if (!s_axis_tvalid || shs) begin
            if (sent < nbeats && (valid_always || $urandom_range(0, 4) != 0)) begin
               s_axis_tvalid = 1'b1;
               s_axis_tdata  = rand512();
               s_axis_tkeep  = (sent % 7 == 3) ? '0 : {$urandom(), $urandom()};
               s_axis_tlast  = (sent == nbeats - 1);
            end else begin
               s_axis_tvalid = 1'b0;
               s_axis_tlast  = 1'b0;
            end
         end
         if (stall_len > 0 && cyc >= stall_from && cyc < stall_from + stall_len)
            m_axis_tready = 1'b0;
         else
            m_axis_tready = ($urandom_range(0, 99) < rdy_pct);
         if (poke_start && cyc == 4) begin
            ctrl_start = 1'b1; ctrl_mode = mode ^ 2'b01;
         end else begin
            ctrl_start = 1'b0;
         end
         @(negedge aclk);
         if (prev_stall) begin
            check_eq("hold_data", m_axis_tdata, held_d);
            check_eq("hold_ctl", D'({m_axis_tvalid, m_axis_tlast, m_axis_tkeep}), D'(held_c));
         end
         if (stall_len > 0 && cyc == stall_from + stall_len - 1) begin
            check_eq("stall_inflight", D'(sent - recv), D'(NS));
            check_eq("stall_s_tready", D'(s_axis_tready), D'(0));
         end
         shs = s_axis_tvalid && s_axis_tready;
         mhs = m_axis_tvalid && m_axis_tready;
         if (shs) begin
            exp_d.push_back(ref_data(mode, s_axis_tdata));
            exp_k.push_back(ref_keep(mode, s_axis_tkeep));
            exp_l.push_back(s_axis_tlast);
            sent++;
         end
         if (mhs) begin
            check_eq("out_queue_nonempty", D'(exp_d.size() != 0), D'(1));
            if (exp_d.size() != 0) begin
               check_eq("beat_data", m_axis_tdata, exp_d.pop_front());
               check_eq("beat_keep", D'(m_axis_tkeep), D'(exp_k.pop_front()));
               check_eq("beat_last", D'(m_axis_tlast), D'(exp_l.pop_front()));
            end
            recv++;
         end
         if (ctrl_done) dones++;
         prev_stall = m_axis_tvalid && !m_axis_tready;
         held_d = m_axis_tdata;
         held_c = {m_axis_tvalid, m_axis_tlast, m_axis_tkeep};
         cyc++;
         if (dones != 0) break;
         @(posedge aclk); #1;
      end
      check_eq("finished_in_budget", D'(cyc < BUDGET), D'(1));
      s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; ctrl_start = 1'b0; m_axis_tready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge aclk);
         if (ctrl_done) dones++;
      end
      check_eq("beats_out", D'(recv), D'(nbeats));
      check_eq("done_pulses", D'(dones), D'(1));
      check_eq("beat_count", D'(ctrl_beat_count), D'(nbeats));
      check_eq("busy_after", D'(ctrl_busy), D'(0));
      check_eq("queue_empty", D'(exp_d.size()), D'(0));
   endtask

   // Two beats end in DRAIN with the output stalled; reset must flush them.
   task automatic reset_in_drain();
      int dones;
      dones = 0;
      @(posedge aclk); #1;
      ctrl_start = 1'b1; ctrl_mode = 2'd2; m_axis_tready = 1'b0;
      @(posedge aclk); #1;
      ctrl_start = 1'b0;
      s_axis_tvalid = 1'b1; s_axis_tdata = rand512(); s_axis_tkeep = '1; s_axis_tlast = 1'b0;
      @(posedge aclk); #1;
      s_axis_tdata = rand512(); s_axis_tlast = 1'b1;
      @(posedge aclk); #1;
      s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
      @(negedge aclk);
      check_eq("drain_busy", D'(ctrl_busy), D'(1));
      check_eq("drain_tvalid", D'(m_axis_tvalid), D'(1));
      check_eq("drain_s_tready", D'(s_axis_tready), D'(0));
      #2 areset = 1'b1;
      #1;
      check_eq("rst_tvalid_now", D'(m_axis_tvalid), D'(0));
      check_eq("rst_busy_now", D'(ctrl_busy), D'(0));
      check_eq("rst_count_now", D'(ctrl_beat_count), D'(0));
      @(posedge aclk); #1;
      areset = 1'b0;
      m_axis_tready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge aclk);
         if (ctrl_done || m_axis_tvalid) dones++;
      end
      check_eq("rst_no_done_no_beat", D'(dones), D'(0));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      areset = 1'b1; ctrl_start = 1'b0; ctrl_mode = 2'd0;
      s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tdata = '0; s_axis_tkeep = '0;
      m_axis_tready = 1'b0;
      repeat (2) @(negedge aclk);
      check_eq("rst_m_tvalid", D'(m_axis_tvalid), D'(0));
      check_eq("rst_s_tready", D'(s_axis_tready), D'(0));
      check_eq("rst_busy", D'(ctrl_busy), D'(0));
      check_eq("rst_done", D'(ctrl_done), D'(0));
      check_eq("rst_count", D'(ctrl_beat_count), D'(0));
      @(posedge aclk); #1;
      areset = 1'b0;
      @(negedge aclk);
      check_eq("idle_s_tready", D'(s_axis_tready), D'(0));

      directed_one(2'd1, 32'h11223344, 4'hF, 32'h44332211, 4'hF);
      directed_one(2'd2, 32'h11223344, 4'h3, 32'h33441122, 4'hC);
      directed_one(2'd3, 32'h11223344, 4'h3, 32'h8844CC22, 4'h3);

      run_stream(2'd1, 100, 50, -1, 0, 1'b0);
      run_stream(2'd3, 40, 100, 10, 10, 1'b0);
      run_stream(2'd2, 30, 70, -1, 0, 1'b1);
      reset_in_drain();
      run_stream(2'd0, 20, 60, -1, 0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
